// File: rtl/user_event_gen.sv
// user_event_gen: turns the five debounced player buttons into a queued stream
// of user_event_t codes. It edge-detects each button, auto-repeats the held
// direction key, merges duplicate pending triggers, and buffers the events in
// a small show-ahead FIFO read through a ready / read-request handshake.

package user_event_pkg;
  typedef enum logic [2:0] {
    EV_NONE     = 3'd0,
    EV_LEFT     = 3'd1,
    EV_RIGHT    = 3'd2,
    EV_DOWN     = 3'd3,
    EV_ROTATE   = 3'd4,
    EV_NEW_GAME = 3'd5
  } user_event_t;
endpackage

module user_event_gen
  import user_event_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        btn_left_i,
  input  logic        btn_right_i,
  input  logic        btn_down_i,
  input  logic        btn_rotate_i,
  input  logic        btn_new_game_i,
  output user_event_t user_event_o,
  output logic        user_event_ready_o,
  input  logic        user_event_rd_req_i,
  output logic        evt_lost_o
);

  // Key bit positions inside the 5-bit button / pending vectors.
  localparam int K_LEFT  = 0;
  localparam int K_RIGHT = 1;
  localparam int K_DOWN  = 2;
  localparam int K_ROT   = 3;
  localparam int K_NEW   = 4;

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int MAX_CNT = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(MAX_CNT);

  localparam logic [CNT_W-1:0] DELAY_LD  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LD = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } rep_state_t;

  // Lowest index wins among direction keys: LEFT > RIGHT > DOWN.
  function automatic logic [1:0] first_dir(input logic [2:0] v);
    logic [1:0] idx;
    idx = 2'd2;
    if (v[1]) idx = 2'd1;
    if (v[0]) idx = 2'd0;
    return idx;
  endfunction

  // One-hot pick of the pending key: NEW_GAME > ROTATE > LEFT > RIGHT > DOWN.
  function automatic logic [4:0] arb_pick(input logic [4:0] pend);
    logic [4:0] sel;
    sel = '0;
    if (pend[K_NEW])        sel[K_NEW]   = 1'b1;
    else if (pend[K_ROT])   sel[K_ROT]   = 1'b1;
    else if (pend[K_LEFT])  sel[K_LEFT]  = 1'b1;
    else if (pend[K_RIGHT]) sel[K_RIGHT] = 1'b1;
    else if (pend[K_DOWN])  sel[K_DOWN]  = 1'b1;
    return sel;
  endfunction

  function automatic user_event_t key_to_event(input logic [4:0] sel);
    user_event_t ev;
    ev = EV_NONE;
    if (sel[K_NEW])        ev = EV_NEW_GAME;
    else if (sel[K_ROT])   ev = EV_ROTATE;
    else if (sel[K_LEFT])  ev = EV_LEFT;
    else if (sel[K_RIGHT]) ev = EV_RIGHT;
    else if (sel[K_DOWN])  ev = EV_DOWN;
    return ev;
  endfunction

  logic [4:0]  w_btn;
  logic [4:0]  r_prev;
  logic        r_armed;
  logic [4:0]  w_rise;
  logic [2:0]  w_dir_rise;

  rep_state_t       r_state, w_state_nxt;
  logic [1:0]       r_held, w_held_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       w_rep_trig;
  logic [2:0]       w_other_rise;
  logic             w_held_lvl;

  logic [4:0]  w_trig;
  logic [4:0]  r_pend;
  logic [4:0]  w_sel;
  logic [4:0]  w_clr;
  user_event_t w_sel_ev;
  logic        r_lost;

  user_event_t r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_wr_en;
  logic             w_rd_en;

  assign w_btn = {btn_new_game_i, btn_rotate_i, btn_down_i, btn_right_i, btn_left_i};

  // The first cycle after reset only captures the button levels, so a button
  // held through reset does not count as a fresh press.
  assign w_rise     = w_btn & ~r_prev & {5{r_armed}};
  assign w_dir_rise = w_rise[2:0];

  // Edge-detect history and the post-reset arming flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_prev  <= '0;
      r_armed <= 1'b0;
    end else begin
      r_prev  <= w_btn;
      r_armed <= 1'b1;
    end
  end

  assign w_held_lvl   = w_btn[r_held];
  assign w_other_rise = w_dir_rise & ~(3'b001 << r_held);

  // Repeat tracker state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_held  <= 2'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_held  <= w_held_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Repeat tracker next state: a new direction press (re)starts the delay,
  // releasing the held key stops it, and each expiry emits one repeat.
  always_comb begin
    w_state_nxt = r_state;
    w_held_nxt  = r_held;
    w_cnt_nxt   = r_cnt;
    w_rep_trig  = '0;
    case (r_state)
      S_IDLE: begin
        if (|w_dir_rise) begin
          w_held_nxt  = first_dir(w_dir_rise);
          w_cnt_nxt   = DELAY_LD;
          w_state_nxt = S_DELAY;
        end
      end
      S_DELAY, S_REPEAT: begin
        if (|w_other_rise) begin
          w_held_nxt  = first_dir(w_other_rise);
          w_cnt_nxt   = DELAY_LD;
          w_state_nxt = S_DELAY;
        end else if (!w_held_lvl) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == '0) begin
          w_rep_trig[r_held] = 1'b1;
          w_cnt_nxt          = PERIOD_LD;
          w_state_nxt        = S_REPEAT;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_trig = w_rise | {2'b00, w_rep_trig};

  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign w_sel    = arb_pick(r_pend);
  assign w_sel_ev = key_to_event(w_sel);
  // A full FIFO still accepts a write when the head is popped the same cycle.
  assign w_wr_en  = (|r_pend) && (!w_full || user_event_rd_req_i);
  assign w_rd_en  = user_event_rd_req_i && !w_empty;
  assign w_clr    = w_wr_en ? w_sel : 5'b0;

  // Pending bits; a retrigger of a key still waiting is merged and flagged.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pend <= '0;
      r_lost <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_trig;
      r_lost <= |(w_trig & r_pend & ~w_clr);
    end
  end

  // Show-ahead event FIFO storage and pointers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= EV_NONE;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr] <= w_sel_ev;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign user_event_o       = r_mem[r_rd_ptr];
  assign user_event_ready_o = !w_empty;
  assign evt_lost_o         = r_lost;

endmodule

// File: tb/tb_user_event_gen.sv
// Directed bench for user_event_gen with a scoreboard of expected events.
module tb_user_event_gen;
  import user_event_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        b_left, b_right, b_down, b_rot, b_ng;
  logic        rd_req;
  user_event_t ev;
  logic        ready;
  logic        lost;

  int n_pass = 0;
  int n_fail = 0;
  user_event_t exp_q[$];

  always #5 clk = ~clk;

  user_event_gen #(
    .FIFO_DEPTH    (4),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (4)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst_n),
    .btn_left_i          (b_left),
    .btn_right_i         (b_right),
    .btn_down_i          (b_down),
    .btn_rotate_i        (b_rot),
    .btn_new_game_i      (b_ng),
    .user_event_o        (ev),
    .user_event_ready_o  (ready),
    .user_event_rd_req_i (rd_req),
    .evt_lost_o          (lost)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Compare the FIFO head with the scoreboard, then pop it for one cycle.
  task automatic pop_check(input string tag);
    user_event_t e;
    check({tag, "_rdy"}, 32'(ready), 32'd1);
    check({tag, "_sb"}, 32'(exp_q.size() != 0), 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : EV_NONE;
    check({tag, "_ev"}, 32'(ev), 32'(e));
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic press(input int k);
    case (k)
      0: b_left  = 1'b1;
      1: b_right = 1'b1;
      2: b_down  = 1'b1;
      3: b_rot   = 1'b1;
      default: b_ng = 1'b1;
    endcase
    tick();
    b_left = 1'b0; b_right = 1'b0; b_down = 1'b0; b_rot = 1'b0; b_ng = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic exp_rdy;
    logic saw;
    rst_n = 1'b0;
    b_left = 1'b0; b_right = 1'b0; b_down = 1'b0; b_rot = 1'b0; b_ng = 1'b0;
    rd_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_event", 32'(ev), 32'(EV_NONE));
    check("rst_lost", 32'(lost), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Single press: LEFT high for 3 cycles, ready two cycles after the rise.
    b_left = 1'b1;
    exp_q.push_back(EV_LEFT);
    tick();
    check("single_lat1", 32'(ready), 32'd0);
    tick();
    check("single_ready", 32'(ready), 32'd1);
    check("single_ev", 32'(ev), 32'(EV_LEFT));
    tick();
    b_left = 1'b0;
    pop_check("single_pop");
    check("single_empty", 32'(ready), 32'd0);
    repeat (15) tick();
    check("single_norep", 32'(ready), 32'd0);

    // Auto-repeat: DOWN held cycles 0..25, reads tied to ready.
    b_down = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back(EV_DOWN);
    for (int c = 1; c <= 34; c++) begin
      tick();
      exp_rdy = (c == 2 || c == 12 || c == 16 || c == 20 || c == 24);
      check($sformatf("rep_rdy_c%0d", c), 32'(ready), 32'(exp_rdy));
      if (ready) begin
        check($sformatf("rep_sb_c%0d", c), 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0)
          check($sformatf("rep_ev_c%0d", c), 32'(ev), 32'(exp_q.pop_front()));
      end
      rd_req = ready;
      if (c == 26) b_down = 1'b0;
    end
    rd_req = 1'b0;
    check("rep_sb_done", 32'(exp_q.size()), 32'd0);

    // Simultaneous presses: priority order, no loss.
    b_ng = 1'b1; b_rot = 1'b1; b_left = 1'b1;
    exp_q.push_back(EV_NEW_GAME);
    exp_q.push_back(EV_ROTATE);
    exp_q.push_back(EV_LEFT);
    for (int c = 1; c <= 5; c++) begin
      tick();
      check($sformatf("simul_lost_c%0d", c), 32'(lost), 32'd0);
    end
    b_ng = 1'b0; b_rot = 1'b0; b_left = 1'b0;
    pop_check("simul_pop0");
    pop_check("simul_pop1");
    pop_check("simul_pop2");
    check("simul_empty", 32'(ready), 32'd0);
    repeat (10) tick();
    check("simul_norep", 32'(ready), 32'd0);

    // Full FIFO: four distinct presses, then RIGHT stays pending, retrigger lost.
    press(0); exp_q.push_back(EV_LEFT);
    press(2); exp_q.push_back(EV_DOWN);
    press(3); exp_q.push_back(EV_ROTATE);
    press(4); exp_q.push_back(EV_NEW_GAME);
    repeat (2) tick();
    check("full_ready", 32'(ready), 32'd1);
    check("full_head", 32'(ev), 32'(EV_LEFT));
    b_right = 1'b1;
    exp_q.push_back(EV_RIGHT);
    tick();
    check("full_r1_lost", 32'(lost), 32'd0);
    b_right = 1'b0;
    tick();
    check("full_r1_lost2", 32'(lost), 32'd0);
    repeat (2) tick();
    b_right = 1'b1;
    tick();
    check("full_r2_lost", 32'(lost), 32'd1);
    b_right = 1'b0;
    tick();
    check("full_r2_pulse_end", 32'(lost), 32'd0);
    tick();
    check("full_head_kept", 32'(ev), 32'(EV_LEFT));

    // Read while full with a pending write: order kept, RIGHT written once.
    pop_check("frw_pop0");
    pop_check("frw_pop1");
    pop_check("frw_pop2");
    pop_check("frw_pop3");
    pop_check("frw_pop4");
    check("frw_empty", 32'(ready), 32'd0);
    repeat (4) tick();
    check("frw_once", 32'(ready), 32'd0);

    // Reset mid-hold: LEFT in REPEAT with two queued entries.
    b_left = 1'b1;
    repeat (13) tick();
    check("mid_ready", 32'(ready), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(ready), 32'd0);
    check("mid_rst_event", 32'(ev), 32'(EV_NONE));
    check("mid_rst_lost", 32'(lost), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    saw = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ready) saw = 1'b1;
    end
    check("mid_held_noevt", 32'(saw), 32'd0);
    b_left = 1'b0;
    tick();
    b_left = 1'b1;
    exp_q.push_back(EV_LEFT);
    tick();
    check("mid_repress_lat", 32'(ready), 32'd0);
    tick();
    b_left = 1'b0;
    pop_check("mid_repress_pop");
    repeat (3) tick();
    check("mid_final_empty", 32'(ready), 32'd0);
    check("sb_final", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
